// File: rtl/prio_encoder_rr_if.sv
// Request/grant bundle for prio_encoder_rr.
// The request side (req, rr_en) has no handshake; the grant side is a
// valid/ready pair carrying both the encoded index and its one-hot form.
interface prio_encoder_rr_if #(
  parameter int N = 8
) ();
  localparam int W = $clog2(N);

  logic [N-1:0] req;
  logic         rr_en;
  logic         out_ready;
  logic         out_valid;
  logic [W-1:0] out_idx;
  logic [N-1:0] out_onehot;

  // Request source / grant consumer side
  modport master (
    output req,
    output rr_en,
    output out_ready,
    input  out_valid,
    input  out_idx,
    input  out_onehot
  );

  // Encoder side
  modport slave (
    input  req,
    input  rr_en,
    input  out_ready,
    output out_valid,
    output out_idx,
    output out_onehot
  );
endinterface

// File: rtl/prio_encoder_rr.sv
// Registered N-to-log2(N) priority encoder with selectable fixed / round-robin
// arbitration and a one-entry valid/ready output register.
// Fixed mode grants the highest set index. Round-robin mode searches downward
// from a pointer that moves to (granted index - 1) mod N on every accepted
// grant, so a fully loaded request vector is granted N-1, N-2, ..., 0, N-1, ...
module prio_encoder_rr #(
  parameter int N = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  prio_encoder_rr_if.slave bus
);
  localparam int W = $clog2(N);

  localparam logic [W-1:0] IDX_ZERO  = {W{1'b0}};
  localparam logic [W-1:0] IDX_ONE   = W'(1'b1);
  localparam logic [W-1:0] PTR_RESET = W'(N - 1);
  localparam logic [N-1:0] OH_ZERO   = {N{1'b0}};
  localparam logic [N-1:0] OH_ONE    = N'(1'b1);

  // Circular predecessor of idx within 0..N-1. The wrap uses N, not 2^W,
  // so non-power-of-two N never produces an index >= N.
  function automatic logic [W-1:0] dec_mod_n(input logic [W-1:0] idx);
    logic [W-1:0] res;
    if (idx == IDX_ZERO) begin
      res = PTR_RESET;
    end else begin
      res = idx - IDX_ONE;
    end
    return res;
  endfunction

  // Highest set index of r; caller guarantees r is non-zero when it matters.
  function automatic logic [W-1:0] pick_fixed(input logic [N-1:0] r);
    logic [W-1:0] res;
    logic [W-1:0] bit_idx;
    res = IDX_ZERO;
    for (int i = 0; i < N; i++) begin
      bit_idx = W'(i);
      if (r[bit_idx]) begin
        res = bit_idx;
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

  // First set index of r in the order start, start-1, ..., 0, N-1, ..., start+1.
  function automatic logic [W-1:0] pick_rr(input logic [N-1:0] r,
                                           input logic [W-1:0] start);
    logic [W-1:0] res;
    logic [W-1:0] cand_idx;
    logic         found;
    int           cand;
    res   = IDX_ZERO;
    found = 1'b0;
    for (int k = 0; k < N; k++) begin
      cand = int'(start) - k;
      if (cand < 0) begin
        cand = cand + N;
      end else begin
        cand = cand;
      end
      cand_idx = W'(cand);
      if (!found && r[cand_idx]) begin
        res   = cand_idx;
        found = 1'b1;
      end else begin
        res   = res;
        found = found;
      end
    end
    return res;
  endfunction

  logic         out_valid_q, out_valid_d;
  logic [W-1:0] out_idx_q,   out_idx_d;
  logic [N-1:0] out_onehot_q, out_onehot_d;
  logic [W-1:0] ptr_q,       ptr_d;

  logic         accept;
  logic         load;
  logic         any_req;
  logic [W-1:0] winner;

  // Handshake decode: a grant leaves on accept, a new one may enter on load.
  always_comb begin
    accept = out_valid_q && bus.out_ready;
    load   = !out_valid_q || bus.out_ready;
  end

  // Round-robin pointer: moves below the grant being accepted in rr mode,
  // otherwise keeps its value so rr mode resumes where it left off.
  always_comb begin
    if (accept && bus.rr_en) begin
      ptr_d = dec_mod_n(out_idx_q);
    end else begin
      ptr_d = ptr_q;
    end
  end

  // Winner search. The rr search starts from the already-advanced pointer so
  // a grant accepted this cycle is not granted again on the same load.
  always_comb begin
    any_req = |bus.req;
    if (bus.rr_en) begin
      winner = pick_rr(bus.req, ptr_d);
    end else begin
      winner = pick_fixed(bus.req);
    end
  end

  // Output register next-state: reload on load, hold bit-stable while stalled.
  always_comb begin
    if (load) begin
      if (any_req) begin
        out_valid_d  = 1'b1;
        out_idx_d    = winner;
        out_onehot_d = OH_ONE << winner;
      end else begin
        out_valid_d  = 1'b0;
        out_idx_d    = IDX_ZERO;
        out_onehot_d = OH_ZERO;
      end
    end else begin
      out_valid_d  = out_valid_q;
      out_idx_d    = out_idx_q;
      out_onehot_d = out_onehot_q;
    end
  end

  // State flops; reset drops any held grant and rewinds the pointer to N-1.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q  <= 1'b0;
      out_idx_q    <= IDX_ZERO;
      out_onehot_q <= OH_ZERO;
      ptr_q        <= PTR_RESET;
    end else begin
      out_valid_q  <= out_valid_d;
      out_idx_q    <= out_idx_d;
      out_onehot_q <= out_onehot_d;
      ptr_q        <= ptr_d;
    end
  end

  assign bus.out_valid  = out_valid_q;
  assign bus.out_idx    = out_idx_q;
  assign bus.out_onehot = out_onehot_q;
endmodule

// File: tb/tb_prio_encoder_rr.sv
// Bench for prio_encoder_rr: three instances (N=4, 8, 5) share the same
// stimulus and run in lockstep against an integer reference model.
module tb_prio_encoder_rr;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] req_v;
  logic       rr_en_v;
  logic       ready_v;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state per instance: 0 -> N=4, 1 -> N=8, 2 -> N=5
  int ns [3] = '{4, 8, 5};
  int m_valid [3];
  int m_idx [3];
  int m_ptr [3];

  prio_encoder_rr_if #(.N(4)) if4 ();
  prio_encoder_rr_if #(.N(8)) if8 ();
  prio_encoder_rr_if #(.N(5)) if5 ();

  assign if4.req = req_v[3:0];
  assign if8.req = req_v;
  assign if5.req = req_v[4:0];
  assign if4.rr_en = rr_en_v;
  assign if8.rr_en = rr_en_v;
  assign if5.rr_en = rr_en_v;
  assign if4.out_ready = ready_v;
  assign if8.out_ready = ready_v;
  assign if5.out_ready = ready_v;

  prio_encoder_rr #(.N(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(if4.slave));
  prio_encoder_rr #(.N(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(if8.slave));
  prio_encoder_rr #(.N(5)) dut5 (.clk(clk), .rst_n(rst_n), .bus(if5.slave));

  always #5 clk = ~clk;

  // Read one instance's outputs, zero-extended (X/Z preserved).
  function automatic void get_obs(input int k, output logic v,
                                  output logic [63:0] idx, output logic [63:0] oh);
    case (k)
      0: begin v = if4.out_valid; idx = 64'(if4.out_idx); oh = 64'(if4.out_onehot); end
      1: begin v = if8.out_valid; idx = 64'(if8.out_idx); oh = 64'(if8.out_onehot); end
      default: begin v = if5.out_valid; idx = 64'(if5.out_idx); oh = 64'(if5.out_onehot); end
    endcase
  endfunction

  // Model: apply one rising edge to every instance using the current inputs.
  task automatic model_step();
    int  n, r, p, c;
    bit  acc, ld, found;
    for (int k = 0; k < 3; k++) begin
      n = ns[k];
      r = int'(req_v) & ((1 << n) - 1);
      if (!rst_n) begin
        m_valid[k] = 0;
        m_idx[k]   = 0;
        m_ptr[k]   = n - 1;
      end else begin
        acc = (m_valid[k] != 0) && ready_v;
        ld  = (m_valid[k] == 0) || ready_v;
        p   = m_ptr[k];
        if (acc && rr_en_v) p = (m_idx[k] + n - 1) % n;
        if (ld) begin
          if (r == 0) begin
            m_valid[k] = 0;
            m_idx[k]   = 0;
          end else begin
            m_valid[k] = 1;
            found = 0;
            for (int s = 0; s < n; s++) begin
              c = rr_en_v ? (p - s + n) % n : (n - 1 - s);
              if (!found && ((r >> c) & 1) != 0) begin
                m_idx[k] = c;
                found = 1;
              end
            end
          end
        end
        m_ptr[k] = p;
      end
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic test_reset();
    logic v; logic [63:0] idx, oh;
    rst_n = 1'b0; req_v = 8'hFF; rr_en_v = 1'b0; ready_v = 1'b1;
    for (int c = 0; c < 2; c++) begin
      cycle();
      for (int k = 0; k < 3; k++) begin
        get_obs(k, v, idx, oh);
        n_cmp++;
        if (v !== 1'b0 || idx !== 64'd0 || oh !== 64'd0) begin
          n_bad++;
          $display("FAIL reset_state n=%0d got v=%b idx=%0d oh=%h required v=0 idx=0 oh=0", ns[k], v, idx, oh);
        end
      end
    end
    rst_n = 1'b1; req_v = 8'h00;
    for (int c = 0; c < 2; c++) begin
      cycle();
      for (int k = 0; k < 3; k++) begin
        get_obs(k, v, idx, oh);
        n_cmp++;
        if (v !== 1'b0 || idx !== 64'd0 || oh !== 64'd0) begin
          n_bad++;
          $display("FAIL idle_after_reset n=%0d got v=%b idx=%0d oh=%h required v=0 idx=0 oh=0", ns[k], v, idx, oh);
        end
      end
    end
  endtask

  task automatic test_legacy();
    logic v; logic [63:0] idx, oh;
    logic exp_v; int exp_i;
    rr_en_v = 1'b0; ready_v = 1'b1;
    for (int r = 0; r < 16; r++) begin
      req_v = 8'(r);
      cycle();
      exp_v = (r != 0);
      exp_i = 0;
      for (int b = 0; b < 4; b++) if (((r >> b) & 1) != 0) exp_i = b;
      get_obs(0, v, idx, oh);
      n_cmp++;
      if (v !== exp_v || idx !== 64'(exp_i) || oh !== (exp_v ? (64'd1 << exp_i) : 64'd0)) begin
        n_bad++;
        $display("FAIL legacy_n4 req=%h got v=%b idx=%0d oh=%h required v=%b idx=%0d", r, v, idx, oh, exp_v, exp_i);
      end
    end
    req_v = 8'h00;
    cycle();
  endtask

  task automatic test_stall();
    logic v; logic [63:0] idx, oh;
    rr_en_v = 1'b0; ready_v = 1'b0; req_v = 8'h10;
    cycle();
    get_obs(1, v, idx, oh);
    n_cmp++;
    if (v !== 1'b1 || idx !== 64'd4 || oh !== 64'h10) begin
      n_bad++;
      $display("FAIL stall_load got v=%b idx=%0d oh=%h required v=1 idx=4 oh=10", v, idx, oh);
    end
    req_v = 8'h80;
    for (int c = 0; c < 3; c++) begin
      cycle();
      get_obs(1, v, idx, oh);
      n_cmp++;
      if (v !== 1'b1 || idx !== 64'd4 || oh !== 64'h10) begin
        n_bad++;
        $display("FAIL stall_hold cyc=%0d got v=%b idx=%0d oh=%h required v=1 idx=4 oh=10", c, v, idx, oh);
      end
    end
    ready_v = 1'b1;
    cycle();
    get_obs(1, v, idx, oh);
    n_cmp++;
    if (v !== 1'b1 || idx !== 64'd7 || oh !== 64'h80) begin
      n_bad++;
      $display("FAIL stall_release got v=%b idx=%0d oh=%h required v=1 idx=7 oh=80", v, idx, oh);
    end
  endtask

  task automatic test_rr_rotation();
    logic v; logic [63:0] idx, oh;
    int exp_i;
    rr_en_v = 1'b0; ready_v = 1'b1; req_v = 8'h00;
    cycle();
    rr_en_v = 1'b1; req_v = 8'hFF;
    for (int i = 0; i < 9; i++) begin
      cycle();
      exp_i = 7 - (i % 8);
      get_obs(1, v, idx, oh);
      n_cmp++;
      if (v !== 1'b1 || idx !== 64'(exp_i) || oh !== (64'd1 << exp_i)) begin
        n_bad++;
        $display("FAIL rr_rotation step=%0d got v=%b idx=%0d oh=%h required idx=%0d", i, v, idx, oh, exp_i);
      end
    end
    req_v = 8'h05;
    for (int i = 0; i < 4; i++) begin
      cycle();
      exp_i = (i % 2 == 0) ? 2 : 0;
      get_obs(1, v, idx, oh);
      n_cmp++;
      if (v !== 1'b1 || idx !== 64'(exp_i)) begin
        n_bad++;
        $display("FAIL rr_alternate step=%0d got v=%b idx=%0d required idx=%0d", i, v, idx, exp_i);
      end
    end
  endtask

  task automatic test_wrap_npot();
    logic v; logic [63:0] idx, oh;
    int exp_i;
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1; rr_en_v = 1'b1; ready_v = 1'b1; req_v = 8'h11;
    for (int i = 0; i < 4; i++) begin
      cycle();
      exp_i = (i % 2 == 0) ? 4 : 0;
      get_obs(2, v, idx, oh);
      n_cmp++;
      if (v !== 1'b1 || idx !== 64'(exp_i) || oh !== (64'd1 << exp_i) || idx > 64'd4) begin
        n_bad++;
        $display("FAIL wrap_n5 step=%0d got v=%b idx=%0d oh=%h required idx=%0d", i, v, idx, oh, exp_i);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic v; logic [63:0] idx, oh;
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1; rr_en_v = 1'b1; ready_v = 1'b1; req_v = 8'hFF;
    for (int i = 0; i < 5; i++) cycle();
    ready_v = 1'b0;
    cycle();
    get_obs(1, v, idx, oh);
    n_cmp++;
    if (v !== 1'b1 || idx !== 64'd3) begin
      n_bad++;
      $display("FAIL reset_mid_setup got v=%b idx=%0d required v=1 idx=3", v, idx);
    end
    rst_n = 1'b0;
    cycle();
    for (int k = 0; k < 3; k++) begin
      get_obs(k, v, idx, oh);
      n_cmp++;
      if (v !== 1'b0 || idx !== 64'd0 || oh !== 64'd0) begin
        n_bad++;
        $display("FAIL reset_mid_clear n=%0d got v=%b idx=%0d oh=%h required all 0", ns[k], v, idx, oh);
      end
    end
    rst_n = 1'b1; ready_v = 1'b1; req_v = 8'hFF;
    cycle();
    get_obs(1, v, idx, oh);
    n_cmp++;
    if (v !== 1'b1 || idx !== 64'd7 || oh !== 64'h80) begin
      n_bad++;
      $display("FAIL reset_mid_regrant got v=%b idx=%0d oh=%h required v=1 idx=7", v, idx, oh);
    end
  endtask

  task automatic test_random();
    logic v; logic [63:0] idx, oh, exp_oh;
    rst_n = 1'b0;
    cycle();
    for (int c = 0; c < 600; c++) begin
      rst_n = ($urandom_range(0, 99) != 0);
      if ($urandom_range(0, 7) == 0) rr_en_v = ~rr_en_v;
      ready_v = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 3))
        0: req_v = 8'h00;
        1: req_v = 8'(1 << $urandom_range(0, 7));
        2: req_v = 8'($urandom) & 8'($urandom);
        default: req_v = 8'($urandom);
      endcase
      cycle();
      for (int k = 0; k < 3; k++) begin
        get_obs(k, v, idx, oh);
        exp_oh = (m_valid[k] != 0) ? (64'd1 << m_idx[k]) : 64'd0;
        n_cmp++;
        if (v !== (m_valid[k] != 0) || idx !== 64'(m_idx[k]) || oh !== exp_oh || idx >= 64'(ns[k])) begin
          n_bad++;
          $display("FAIL random n=%0d cyc=%0d got v=%b idx=%0d oh=%h required v=%0d idx=%0d oh=%h",
                   ns[k], c, v, idx, oh, m_valid[k], m_idx[k], exp_oh);
        end
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; req_v = 8'h00; rr_en_v = 1'b0; ready_v = 1'b1;
    for (int k = 0; k < 3; k++) begin
      m_valid[k] = 0; m_idx[k] = 0; m_ptr[k] = ns[k] - 1;
    end
    test_reset();
    test_legacy();
    test_stall();
    test_rr_rotation();
    test_wrap_npot();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
